otter_pipe_chain: RTL

Parametrised multi-stage pipeline register chain that carries a data word and a valid bit through DEPTH stages. It supports a partial stall: the first HOLD_STAGES stages freeze while downstream stages keep advancing, and a bubble is inserted behind the frozen stages. It also provides per-stage squash, a global flush and an occupancy count. It is the next-generation replacement for the bare per-signal pipeline registers in the pipelined OTTER MCU, with bubble and squash tracking built in.

---
 rtl/otter_pipe_chain.sv | 100 ++++++++++
 1 files changed

// File: rtl/otter_pipe_chain.sv
// otter_pipe_chain: a DEPTH-stage register chain that carries a data word and a
// valid bit per stage. A stall freezes the leading HOLD_STAGES stages and drops
// a bubble into the first free stage. Per-stage squash, global flush and a
// popcount occupancy are also provided. Every output comes straight from
// registers, so squash, stall and flush_all reach no output without a clock edge.
module otter_pipe_chain #(
    parameter int               DEPTH       = 4,
    parameter int               WIDTH       = 32,
    parameter int               HOLD_STAGES = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic [DEPTH-1:0]           squash,
    input  logic                       flush_all,
    output logic [DEPTH*WIDTH-1:0]     data_out,
    output logic [DEPTH-1:0]           valid_out,
    output logic [WIDTH-1:0]           tail_data,
    output logic                       tail_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       empty
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [WIDTH-1:0] w_data_nxt [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [OCC_W-1:0] w_occ;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // Where this stage sits relative to the frozen region.
        localparam bit HELD   = (g < HOLD_STAGES);
        localparam bit BUBBLE = (HOLD_STAGES > 0) && (g == HOLD_STAGES);

        logic [WIDTH-1:0] w_src_data;
        logic             w_src_valid;

        if (g == 0) begin : g_head
            assign w_src_data  = in_data;
            assign w_src_valid = in_valid;
        end else begin : g_body
            // A squashed upstream entry still moves its data but arrives dead.
            assign w_src_data  = r_data[g-1];
            assign w_src_valid = r_valid[g-1] & ~squash[g-1];
        end

        // Held stages keep their word; all others load the upstream word.
        // The bubble stage also loads it, so the bubble carries a copy of the
        // frozen entry's data, but never its valid bit.
        assign w_data_nxt[g] = (stall && HELD) ? r_data[g] : w_src_data;

        // Priority: flush, then held (squash in place), then bubble, then advance.
        assign w_valid_nxt[g] = flush_all        ? 1'b0 :
                                (stall && HELD)   ? (r_valid[g] & ~squash[g]) :
                                (stall && BUBBLE) ? 1'b0 :
                                                    w_src_valid;

        assign data_out[g*WIDTH +: WIDTH] = r_data[g];
    end

    // Stage registers: synchronous reset, otherwise load the computed next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: every stage is a plain flop, not RAM, so resetting the data
            // words too is cheap and makes data_out deterministic after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the old
            // value of its neighbour, which is what makes this a shift chain.
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            r_valid <= w_valid_nxt;
        end
    end

    // Occupancy is a popcount of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    assign valid_out  = r_valid;
    assign tail_data  = r_data[DEPTH-1];
    assign tail_valid = r_valid[DEPTH-1];
    assign occupancy  = w_occ;
    assign empty      = (r_valid == '0);

endmodule
